// File: rtl/axil_req_arbiter.sv
// Two-requester round-robin arbiter driving a single AXI4-Lite master port, one transaction at a time.
// Optional stall timeout is compiled in with AXIL_ARB_TIMEOUT_EN.
module axil_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_wstrb,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_wstrb,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             gnt_q, gnt_d;
    logic [1:0]       rdy_q, rdy_d;
    logic [1:0]       rsp_vld_q, rsp_vld_d;
    logic [1:0]       rsp_err_q, rsp_err_d;
    logic [1:0][31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0]      awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic             arvalid_q, arvalid_d, rready_q, rready_d;
    logic [31:0]      res_rdata_q, res_rdata_d;
    logic             res_err_q, res_err_d;

    req_t req0_in, req1_in, sel_req;
    logic pick;
    logic tmo;

    assign req0_in = '{write: req0_write, addr: req0_addr, wdata: req0_wdata, wstrb: req0_wstrb};
    assign req1_in = '{write: req1_write, addr: req1_addr, wdata: req1_wdata, wstrb: req1_wstrb};
    // prio_q names the requester that wins a tie; a lone request wins outright
    assign pick    = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign sel_req = pick ? req1_in : req0_in;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy;
    logic          unused_ok;

    assign busy      = state_q inside {WADDR, WRESP, RADDR, RDATA};
    assign tmo       = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign unused_ok = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) cnt_d = '0;
        else if (busy)       cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    logic unused_ok;
    assign tmo       = 1'b0;
    assign unused_ok = ^{M_AXI_BRESP[0], M_AXI_RRESP[0], 32'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        rdy_d       = '0;
        rsp_vld_d   = '0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        res_rdata_d = res_rdata_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_d       = pick;
                    prio_d      = ~pick;
                    rdy_d[pick] = 1'b1;
                    res_rdata_d = '0;
                    res_err_d   = 1'b0;
                    if (sel_req.write) begin
                        awaddr_d  = sel_req.addr;
                        wdata_d   = sel_req.wdata;
                        wstrb_d   = sel_req.wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WADDR;
                    end else begin
                        araddr_d  = sel_req.addr;
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WADDR: begin
                // AW and W complete independently; leave once both are accepted
                awvalid_d = awvalid_q && !M_AXI_AWREADY;
                wvalid_d  = wvalid_q && !M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    res_err_d = M_AXI_BRESP[1];
                    bready_d  = 1'b0;
                    state_d   = RSP;
                end
            end
            RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID) begin
                    res_rdata_d = M_AXI_RDATA;
                    res_err_d   = M_AXI_RRESP[1];
                    rready_d    = 1'b0;
                    state_d     = RSP;
                end
            end
            RSP: begin
                rsp_vld_d[gnt_q]   = 1'b1;
                rsp_rdata_d[gnt_q] = res_rdata_q;
                rsp_err_d[gnt_q]   = res_err_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A stalled slave is abandoned: all handshakes withdrawn, error reported
        if (tmo) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            res_rdata_d = '0;
            res_err_d   = 1'b1;
            state_d     = RSP;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            rdy_q       <= '0;
            rsp_vld_q   <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            res_rdata_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            rdy_q       <= rdy_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
        end
    end

    assign req0_ready    = rdy_q[0];
    assign req1_ready    = rdy_q[1];
    assign rsp0_valid    = rsp_vld_q[0];
    assign rsp1_valid    = rsp_vld_q[1];
    assign rsp0_rdata    = rsp_rdata_q[0];
    assign rsp1_rdata    = rsp_rdata_q[1];
    assign rsp0_err      = rsp_err_q[0];
    assign rsp1_err      = rsp_err_q[1];
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axil_req_arbiter.md
AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 256, stall limit in ACLK cycles, used only when the timeout feature is compiled in.
REQ-002 SHALL have port: ACLK  in  1  single clock; every flop is on its rising edge.
REQ-003 SHALL have port: ARESETN  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: reqN_valid  in  1  request from requester N, with N = 0 and N = 1.
REQ-005 SHALL have port: reqN_ready  out  1  one-cycle grant pulse; request fields are captured in that cycle.
REQ-006 SHALL have port: reqN_write  in  1  1 = write, 0 = read.
REQ-007 SHALL have port: reqN_addr  in  32  register byte address.
REQ-008 SHALL have port: reqN_wdata  in  32  write data.
REQ-009 SHALL have port: reqN_wstrb  in  4  write byte strobes.
REQ-010 SHALL have port: rspN_valid  out  1  one-cycle completion pulse to requester N.
REQ-011 SHALL have port: rspN_rdata  out  32  read data; 0 for writes.
REQ-012 SHALL have port: rspN_err  out  1  error flag: RESP[1] of the AXI response, or a timeout.
REQ-013 SHALL have port: M_AXI_AWADDR  out  32  write address.
REQ-014 SHALL have port: M_AXI_AWVALID  out  1  write address valid.
REQ-015 SHALL have port: M_AXI_AWREADY  in  1  write address ready.
REQ-016 SHALL have port: M_AXI_WDATA  out  32  write data.
REQ-017 SHALL have port: M_AXI_WSTRB  out  4  write strobes.
REQ-018 SHALL have port: M_AXI_WVALID  out  1  write data valid.
REQ-019 SHALL have port: M_AXI_WREADY  in  1  write data ready.
REQ-020 SHALL have port: M_AXI_BRESP  in  2  write response code.
REQ-021 SHALL have port: M_AXI_BVALID  in  1  write response valid.
REQ-022 SHALL have port: M_AXI_BREADY  out  1  write response ready.
REQ-023 SHALL have port: M_AXI_ARADDR  out  32  read address.
REQ-024 SHALL have port: M_AXI_ARVALID  out  1  read address valid.
REQ-025 SHALL have port: M_AXI_ARREADY  in  1  read address ready.
REQ-026 SHALL have port: M_AXI_RDATA  in  32  read data.
REQ-027 SHALL have port: M_AXI_RRESP  in  2  read response code.
REQ-028 SHALL have port: M_AXI_RVALID  in  1  read data valid.
REQ-029 SHALL have port: M_AXI_RREADY  out  1  read data ready.

Function
REQ-030 SHALL use FSM states IDLE, WADDR, WRESP, RADDR, RDATA and RSP; only one transaction is outstanding at a time.
REQ-031 SHALL arbitrate in IDLE by round-robin: if both requests are valid, grant the requester not granted last; a single valid request is granted immediately; after reset, req0 has priority.
REQ-032 SHALL, on grant, pulse reqN_ready for 1 cycle, register addr/wdata/wstrb/write, and move to WADDR (write) or RADDR (read).
REQ-033 SHALL, in WADDR, assert AWVALID and WVALID together; each drops independently on its own ready and never drops before that ready; once both handshakes are done, go to WRESP.
REQ-034 SHALL hold BREADY = 1 in WRESP; on BVALID, latch BRESP and go to RSP.
REQ-035 SHALL hold ARVALID in RADDR until ARREADY, then go to RDATA, where RREADY = 1; on RVALID, latch RDATA/RRESP and go to RSP.
REQ-036 SHALL, in RSP, pulse rspN_valid for 1 cycle to the granted N, then return to IDLE; all outputs are registered.
REQ-037 SHALL, against a zero-wait slave, assert rspN_valid exactly 3 cycles after the reqN_ready pulse.
REQ-038 SHALL keep requests that arrive while busy pending; a request withdrawn before its ready pulse produces no transaction.

Reset
REQ-039 SHALL, while ARESETN = 0, asynchronously force the FSM to IDLE, all VALID/READY/pulse outputs to 0, data outputs to 0, and the round-robin pointer to favour req0; no response is issued for a transaction aborted by reset.

Configuration
REQ-040 SHALL, with AXIL_ARB_TIMEOUT_EN defined, count cycles spent in WADDR/WRESP/RADDR/RDATA; on reaching TIMEOUT_CYCLES, drop all AXI valids/readies, go to RSP with rspN_err = 1 and rspN_rdata = 0.
REQ-041 SHALL, without AXIL_ARB_TIMEOUT_EN, contain no counter, wait indefinitely, and ignore TIMEOUT_CYCLES.

Verification
REQ-042 SHALL cover: req0 write addr 0x10, data 0xA5A5_5A5A, wstrb 0xF, zero-wait slave -> AW/W carry these values; rsp0_valid 3 cycles after req0_ready; err 0.
REQ-043 SHALL cover: req0 and req1 both valid continuously from reset -> grant order 0,1,0,1.
REQ-044 SHALL cover: req1 read addr 0x4, ARREADY delayed 5 cycles, RDATA 0xDEADBEEF -> ARVALID held 5 cycles; rsp1_rdata 0xDEADBEEF.
REQ-045 SHALL cover: BRESP 2'b10 on a write -> rsp_err 1; ARESETN pulsed low in WRESP -> outputs 0, no rsp, next request completes normally.
REQ-046 SHALL cover: with AXIL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES 16, AWREADY stuck at 0 -> AWVALID drops after 16 cycles; rsp_err 1.
